// File: rtl/mutative_types.sv
// Shared types for the mutative cache memory-side arbiter: grant states,
// the registered memory request record and the port count.
package mutative_types;

    localparam int ARB_PORTS      = 2;
    localparam int MUT_ADDR_WIDTH = 32;
    localparam int MUT_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [MUT_ADDR_WIDTH-1:0] addr;
        logic                      read;
        logic                      write;
        logic [MUT_LINE_WIDTH-1:0] wdata;
    } dfp_req_t;

    // A write always wins over a read raised in the same cycle by the same port.
    function automatic dfp_req_t make_req(
        input logic [MUT_ADDR_WIDTH-1:0] addr,
        input logic                      read,
        input logic                      write,
        input logic [MUT_LINE_WIDTH-1:0] wdata
    );
        dfp_req_t r;
        r.addr  = addr;
        r.read  = read & ~write;
        r.write = write;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mutative_dfp_arbiter_if.sv
// One line-transaction port: the requester side is master, the responder side is slave.
interface mutative_dfp_arbiter_if
    import mutative_types::*;
#(
    parameter int ADDR_WIDTH = MUT_ADDR_WIDTH,
    parameter int LINE_WIDTH = MUT_LINE_WIDTH
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (
        output addr, read, write, wdata,
        input  rdata, resp
    );

    modport slave (
        input  addr, read, write, wdata,
        output rdata, resp
    );

endinterface

// File: rtl/mutative_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the port
// that was not served last.
module mutative_rr_pick
    import mutative_types::*;
(
    input  logic [ARB_PORTS-1:0] req,
    input  logic                 last_served,
    output logic                 grant_idx,
    output logic                 grant_valid
);

    assign grant_valid = |req;
    assign grant_idx   = (&req) ? ~last_served : req[1];

endmodule

// File: rtl/mutative_dfp_arbiter.sv
// Shares the single memory port between the I-side (p0) and D-side (p1) caches.
// Define MUTATIVE_ARB_WB_LOCK_EN to keep the grant for a refill read issued right after a writeback.
module mutative_dfp_arbiter
    import mutative_types::*;
(
    input logic                         clk,
    input logic                         rst_n,
    mutative_dfp_arbiter_if.slave       p0,
    mutative_dfp_arbiter_if.slave       p1,
    mutative_dfp_arbiter_if.master      dfp
);

`ifdef MUTATIVE_ARB_WB_LOCK_EN
    localparam bit WB_LOCK = 1'b1;
`else
    localparam bit WB_LOCK = 1'b0;
`endif

    arb_state_t           state_q, state_d;
    logic                 last_q, last_d;
    logic                 lock_q, lock_d;
    dfp_req_t             req_q, req_d;
    dfp_req_t             req0, req1, cur_req;
    logic [ARB_PORTS-1:0] req_vec;
    logic                 gidx;
    logic                 cur_active;
    logic                 resp_hit;
    logic                 pick_idx;
    logic                 pick_valid;

    assign req0       = make_req(p0.addr, p0.read, p0.write, p0.wdata);
    assign req1       = make_req(p1.addr, p1.read, p1.write, p1.wdata);
    assign req_vec    = {p1.read | p1.write, p0.read | p0.write};
    assign gidx       = (state_q == GRANT1);
    assign cur_req    = gidx ? req1 : req0;
    assign cur_active = req_vec[gidx];

    mutative_rr_pick u_pick (
        .req         (req_vec),
        .last_served (last_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        lock_d   = 1'b0;
        req_d    = req_q;
        resp_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = pick_idx ? GRANT1 : GRANT0;
                    req_d   = pick_idx ? req1 : req0;
                end
            end
            GRANT0, GRANT1: begin
                if (lock_q) begin
                    // One-cycle window after a writeback: only a refill read keeps the grant.
                    if (cur_req.read) begin
                        req_d = cur_req;
                    end else begin
                        state_d = IDLE;
                        last_d  = gidx;
                        req_d   = '0;
                    end
                end else if (dfp.resp) begin
                    // A requester that already dropped its request gets no resp.
                    resp_hit = cur_active;
                    req_d    = '0;
                    if (WB_LOCK && req_q.write) begin
                        lock_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        last_d  = gidx;
                    end
                end else if (cur_active) begin
                    req_d = cur_req;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    assign dfp.addr  = req_q.addr;
    assign dfp.read  = req_q.read;
    assign dfp.write = req_q.write;
    assign dfp.wdata = req_q.wdata;

    assign p0.rdata = dfp.rdata;
    assign p1.rdata = dfp.rdata;
    assign p0.resp  = rst_n & resp_hit & ~gidx;
    assign p1.resp  = rst_n & resp_hit & gidx;

    // Raising read and write together on one port breaks the cache protocol.
    p0_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(p0.read && p0.write));
    p1_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(p1.read && p1.write));

endmodule

// File: tb/tb_mutative_dfp_arbiter.sv
// Self-checking bench for mutative_dfp_arbiter: arbitration table, directed
// corner sequences and a randomized two-cache / one-memory run against a model.
module tb_mutative_dfp_arbiter;

`ifdef MUTATIVE_ARB_WB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mutative_dfp_arbiter_if p0_bus ();
    mutative_dfp_arbiter_if p1_bus ();
    mutative_dfp_arbiter_if dfp_bus ();

    mutative_dfp_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p0    (p0_bus),
        .p1    (p1_bus),
        .dfp   (dfp_bus)
    );

    typedef struct {
        bit          prime;
        bit          prime_port;
        bit          r0, w0, r1, w1;
        bit          exp_rd, exp_wr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t         vecs[9];
    logic [255:0] line0, line1, line_a5, line_dead, line, exp_wd;
    logic [31:0]  a;
    bit           w, r0, r1;
    int           s, n0, mcyc, p, exp_s;

    // random-run model state
    bit           c_act[2], c_rd[2], c_wr[2], c_done[2];
    logic [31:0]  c_addr[2];
    logic [255:0] c_data[2];
    int           c_gap[2], c_wait[2];
    int           m_owner, m_lat, exp_p;
    bit           m_last;
    bit [1:0]     prev_pend;
    bit           exp0, exp1;

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input int port, input bit rd, input bit wr,
                         input logic [31:0] ad, input logic [255:0] d);
        if (port == 0) begin
            p0_bus.read = rd; p0_bus.write = wr; p0_bus.addr = ad; p0_bus.wdata = d;
        end else begin
            p1_bus.read = rd; p1_bus.write = wr; p1_bus.addr = ad; p1_bus.wdata = d;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        dfp_bus.resp  = 1'b0;
        dfp_bus.rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a memory strobe, answers after lat cycles with ln.
    // Returns in the response cycle with the per-port resp values sampled.
    task automatic serve(input int lat, input logic [255:0] ln, output logic [31:0] ad,
                         output bit wr, output int sc, output bit q0, output bit q1);
        int n;
        n = 0;
        settle();
        while (!(dfp_bus.read || dfp_bus.write) && n < 30) begin
            tick();
            settle();
            n++;
        end
        chk("serve_strobe", dfp_bus.read | dfp_bus.write, 1'b1);
        ad = dfp_bus.addr;
        wr = dfp_bus.write;
        sc = cyc;
        for (int i = 0; i < lat; i++) tick();
        dfp_bus.resp  = 1'b1;
        dfp_bus.rdata = ln;
        settle();
        q0 = p0_bus.resp;
        q1 = p1_bus.resp;
    endtask

    task automatic finish_txn(input int port);
        tick();
        dfp_bus.resp = 1'b0;
        drive(port, 0, 0, '0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line0     = {8{32'h0123_4567}};
        line1     = {8{32'h89AB_CDEF}};
        line_a5   = {32{8'hA5}};
        line_dead = {8{32'hDEAD_BEEF}};
        //         prime pport r0 w0 r1 w1 rd wr addr
        vecs[0] = '{0, 0, 1, 0, 0, 0, 1, 0, 32'hA000};
        vecs[1] = '{0, 0, 0, 0, 0, 1, 0, 1, 32'hB000};
        vecs[2] = '{0, 0, 1, 0, 1, 0, 1, 0, 32'hA000};
        vecs[3] = '{1, 0, 1, 0, 1, 0, 1, 0, 32'hB000};
        vecs[4] = '{1, 1, 1, 0, 0, 1, 1, 0, 32'hA000};
        vecs[5] = '{1, 0, 0, 1, 0, 1, 0, 1, 32'hB000};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0000};
        vecs[7] = '{1, 1, 0, 1, 0, 0, 0, 1, 32'hA000};
        vecs[8] = '{1, 1, 0, 0, 1, 0, 1, 0, 32'hB000};

        // reset values
        do_reset();
        settle();
        chk("rst_dfp_read", dfp_bus.read, 1'b0);
        chk("rst_dfp_write", dfp_bus.write, 1'b0);
        chk("rst_dfp_addr", dfp_bus.addr, 32'h0);
        chk("rst_dfp_wdata", dfp_bus.wdata, '0);
        chk("rst_p0_resp", p0_bus.resp, 1'b0);
        chk("rst_p1_resp", p1_bus.resp, 1'b0);

        // single I-side read, memory answers 5 cycles after the strobe
        drive(0, 1, 0, 32'h0000_1000, '0);
        tick();
        settle();
        chk("t1_strobe_n1", dfp_bus.read, 1'b1);
        chk("t1_addr", dfp_bus.addr, 32'h0000_1000);
        chk("t1_write", dfp_bus.write, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("t1_early_resp", p0_bus.resp, 1'b0);
        end
        tick();
        dfp_bus.resp  = 1'b1;
        dfp_bus.rdata = line_a5;
        settle();
        chk("t1_p0_resp", p0_bus.resp, 1'b1);
        chk("t1_p1_resp", p1_bus.resp, 1'b0);
        chk("t1_p0_rdata", p0_bus.rdata, line_a5);
        chk("t1_p1_rdata", p1_bus.rdata, line_a5);
        finish_txn(0);
        settle();
        chk("t1_resp_one_cycle", p0_bus.resp, 1'b0);
        chk("t1_idle_strobe", dfp_bus.read, 1'b0);

        // arbitration table
        foreach (vecs[i]) begin
            do_reset();
            if (vecs[i].prime) begin
                drive(vecs[i].prime_port, 1, 0, 32'h0F00, '0);
                tick();
                serve(1, line0, a, w, s, r0, r1);
                finish_txn(vecs[i].prime_port);
            end
            drive(0, vecs[i].r0, vecs[i].w0, 32'hA000, line0);
            drive(1, vecs[i].r1, vecs[i].w1, 32'hB000, line1);
            tick();
            settle();
            exp_wd = (vecs[i].exp_addr == 32'hB000) ? line1 :
                     (vecs[i].exp_addr == 32'hA000) ? line0 : '0;
            chk($sformatf("vec%0d_read", i), dfp_bus.read, vecs[i].exp_rd);
            chk($sformatf("vec%0d_write", i), dfp_bus.write, vecs[i].exp_wr);
            chk($sformatf("vec%0d_addr", i), dfp_bus.addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_wdata", i), dfp_bus.wdata, exp_wd);
        end

        // both read continuously: strict alternation, next strobe two cycles after resp
        do_reset();
        drive(0, 1, 0, 32'h100, '0);
        drive(1, 1, 0, 32'h200, '0);
        n0 = cyc;
        tick();
        mcyc = 0;
        for (int k = 0; k < 4; k++) begin
            serve(2, line0, a, w, s, r0, r1);
            exp_s = (k == 0) ? n0 + 1 : mcyc + 2;
            chk("alt_timing", s, exp_s);
            chk("alt_addr", a, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("alt_resp0", r0, (k % 2 == 0));
            chk("alt_resp1", r1, (k % 2 == 1));
            mcyc = cyc;
            p = k % 2;
            finish_txn(p);
            settle();
            chk("alt_idle_gap", dfp_bus.read, 1'b0);
            tick();
            drive(p, 1, 0, (p == 0) ? 32'h100 : 32'h200, '0);
        end

        // D-side writeback then refill while the I-side read waits
        do_reset();
        drive(1, 0, 1, 32'h2000, line_dead);
        tick();
        drive(0, 1, 0, 32'h4000, '0);
        serve(2, line0, a, w, s, r0, r1);
        chk("wb_addr", a, 32'h2000);
        chk("wb_write", w, 1'b1);
        chk("wb_wdata", dfp_bus.wdata, line_dead);
        chk("wb_p1_resp", r1, 1'b1);
        chk("wb_p0_resp", r0, 1'b0);
        mcyc = cyc;
        tick();
        dfp_bus.resp = 1'b0;
        drive(1, 1, 0, 32'h3000, '0);
        serve(2, line1, a, w, s, r0, r1);
        chk("wb_second_addr", a, LOCK_ON ? 32'h3000 : 32'h4000);
        chk("wb_second_timing", s, mcyc + 2);
        p = (a == 32'h3000) ? 1 : 0;
        finish_txn(p);
        serve(1, line0, a, w, s, r0, r1);
        chk("wb_third_addr", a, LOCK_ON ? 32'h4000 : 32'h3000);
        finish_txn((a == 32'h3000) ? 1 : 0);

        // memory response while idle is ignored
        do_reset();
        dfp_bus.resp = 1'b1;
        settle();
        chk("idle_resp_p0", p0_bus.resp, 1'b0);
        chk("idle_resp_p1", p1_bus.resp, 1'b0);
        tick();
        dfp_bus.resp = 1'b0;
        drive(0, 1, 0, 32'h5000, '0);
        tick();
        settle();
        chk("idle_after_strobe", dfp_bus.read, 1'b1);
        chk("idle_after_addr", dfp_bus.addr, 32'h5000);

        // reset while the D-side is granted
        do_reset();
        drive(1, 1, 0, 32'h6000, '0);
        tick();
        settle();
        chk("rstg_strobe", dfp_bus.read, 1'b1);
        tick();
        rst_n = 1'b0;
        drive(1, 0, 0, '0, '0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("rstg_read_low", dfp_bus.read, 1'b0);
        chk("rstg_write_low", dfp_bus.write, 1'b0);
        dfp_bus.resp = 1'b1;
        settle();
        chk("rstg_no_p1_resp", p1_bus.resp, 1'b0);
        tick();
        dfp_bus.resp = 1'b0;
        drive(0, 1, 0, 32'h7000, '0);
        drive(1, 1, 0, 32'h8000, '0);
        tick();
        settle();
        chk("rstg_tie_port0", dfp_bus.addr, 32'h7000);

        // requester drops while granted: grant held, late response swallowed
        do_reset();
        drive(0, 1, 0, 32'h9000, '0);
        tick();
        drive(0, 0, 0, '0, '0);
        tick();
        settle();
        chk("drop_hold_read", dfp_bus.read, 1'b1);
        chk("drop_hold_addr", dfp_bus.addr, 32'h9000);
        dfp_bus.resp = 1'b1;
        settle();
        chk("drop_swallow", p0_bus.resp, 1'b0);
        tick();
        dfp_bus.resp = 1'b0;
        settle();
        chk("drop_idle", dfp_bus.read, 1'b0);

        // randomized traffic against a transaction-level model
        do_reset();
        m_owner = -1;
        m_last = 1'b1;
        m_lat = 0;
        prev_pend = 2'b00;
        for (int i = 0; i < 2; i++) begin
            c_act[i] = 0; c_done[i] = 0; c_gap[i] = 0; c_wait[i] = 0;
            c_rd[i] = 0; c_wr[i] = 0; c_addr[i] = '0; c_data[i] = '0;
        end
        for (int t = 0; t < 4000; t++) begin
            tick();
            if (m_owner < 0 && (dfp_bus.read || dfp_bus.write)) begin
                chk("rand_grant_pending", prev_pend != 2'b00, 1'b1);
                if (prev_pend != 2'b00) begin
                    exp_p = (prev_pend == 2'b11) ? (m_last ? 0 : 1) : (prev_pend[0] ? 0 : 1);
                    chk("rand_grant_addr", dfp_bus.addr, c_addr[exp_p]);
                    chk("rand_grant_read", dfp_bus.read, c_rd[exp_p]);
                    chk("rand_grant_write", dfp_bus.write, c_wr[exp_p]);
                    chk("rand_grant_wdata", dfp_bus.wdata, c_data[exp_p]);
                    m_owner = exp_p;
                    m_lat = $urandom_range(0, 3);
                    c_wait[exp_p] = 0;
                end
            end else if (m_owner >= 0) begin
                chk("rand_hold_strobe", dfp_bus.read | dfp_bus.write, 1'b1);
                chk("rand_hold_addr", dfp_bus.addr, c_addr[m_owner]);
            end
            for (int i = 0; i < 2; i++) begin
                if (c_done[i]) begin
                    c_act[i] = 0;
                    c_done[i] = 0;
                    c_gap[i] = $urandom_range(1, 4);
                end else if (!c_act[i]) begin
                    if (c_gap[i] > 0) c_gap[i]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        c_act[i] = 1;
                        c_wr[i] = ($urandom_range(0, 1) == 1);
                        c_rd[i] = !c_wr[i];
                        c_addr[i] = $urandom;
                        c_data[i] = rand_line();
                    end
                end
                if (c_act[i] && m_owner != i) c_wait[i]++;
                if (c_wait[i] > 40) begin
                    chk("rand_starve", c_wait[i], 0);
                    c_wait[i] = 0;
                end
                drive(i, c_act[i] & c_rd[i], c_act[i] & c_wr[i], c_addr[i], c_data[i]);
            end
            line = rand_line();
            dfp_bus.rdata = line;
            if (m_owner >= 0) begin
                if (m_lat == 0) dfp_bus.resp = 1'b1;
                else begin
                    dfp_bus.resp = 1'b0;
                    m_lat--;
                end
            end else begin
                dfp_bus.resp = ($urandom_range(0, 7) == 0);
            end
            settle();
            exp0 = dfp_bus.resp && (m_owner == 0);
            exp1 = dfp_bus.resp && (m_owner == 1);
            chk("rand_p0_resp", p0_bus.resp, exp0);
            chk("rand_p1_resp", p1_bus.resp, exp1);
            if (dfp_bus.resp && m_owner >= 0) begin
                chk("rand_rdata", (m_owner == 0) ? p0_bus.rdata : p1_bus.rdata, line);
                c_done[m_owner] = 1;
                m_last = (m_owner == 1);
                m_owner = -1;
            end
            prev_pend = {c_act[1], c_act[0]};
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
